// File: rtl/vec_reg_pkg.sv
// Shared definitions for the vector register file and its port scheduler.
// The register file holds VREG_NUM registers of VREG_DATA_W bits and is
// accessed in pairs {reg[a+1], reg[a]} of VREG_PAIR_W bits. The pair index
// wraps, so address 3 pairs with register 0.
package vec_reg_pkg;

  localparam int VREG_NUM    = 4;
  localparam int VREG_ADDR_W = 2;
  localparam int VREG_DATA_W = 32;
  localparam int VREG_PAIR_W = 64;

  typedef logic [VREG_ADDR_W-1:0] vreg_addr_t;
  typedef logic [VREG_PAIR_W-1:0] vreg_pair_t;

endpackage

// File: rtl/vec_reg_port_sched_if.sv
// Bundle of requester-side handshakes and register-file port signals for
// vec_reg_port_sched.
//   slave  : the scheduler (consumes requests, drives grants/responses and
//            the register-file write/read address ports)
//   master : the environment (requesters plus the register file itself)
// Requester i owns slice i of every packed per-requester field.
interface vec_reg_port_sched_if
  import vec_reg_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]             wr_valid;
  logic [VREG_ADDR_W*NUM_REQ-1:0] wr_addr;
  logic [VREG_PAIR_W*NUM_REQ-1:0] wr_data;
  logic [NUM_REQ-1:0]             wr_ready;

  logic [NUM_REQ-1:0]             rd_valid;
  logic [VREG_ADDR_W*NUM_REQ-1:0] rd_addr;
  logic [NUM_REQ-1:0]             rd_ready;
  logic [NUM_REQ-1:0]             rd_resp_valid;
  vreg_pair_t                     rd_resp_data;

  logic                           vr_we;
  vreg_addr_t                     vr_addr_w;
  vreg_pair_t                     vr_wdata;
  vreg_addr_t                     vr_addr_r;
  logic [VREG_DATA_W-1:0]         vr_rdata1;
  logic [VREG_DATA_W-1:0]         vr_rdata2;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, vr_rdata1, vr_rdata2,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
           vr_we, vr_addr_w, vr_wdata, vr_addr_r
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, vr_rdata1, vr_rdata2,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
           vr_we, vr_addr_w, vr_wdata, vr_addr_r
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk   : clock, pointer updates on the rising edge
//   rst   : asynchronous active-low reset, pointer returns to 0
//   req   : per-requester request
//   grant : one-hot combinational grant; the first requester at or after the
//           pointer wins, and the pointer moves past the winner on any grant
// No grant is issued while rst is low.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [N-1:0]     w_grant;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // NOTE: every signal driven here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant = '0;
    w_win   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      // Candidate index (r_ptr + k) mod N without a divider.
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N)) w_sum = w_sum - (PTR_W+1)'(N);
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_win          = w_idx;
        w_found        = 1'b1;
      end
    end
  end

  assign grant = rst ? w_grant : '0;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (|grant) begin
      r_ptr <= (w_win == PTR_W'(N-1)) ? '0 : w_win + PTR_W'(1);
    end
  end

endmodule

// File: rtl/vec_reg_port_sched.sv
// Round-robin port scheduler sharing the 4x32 vector register file between
// NUM_REQ requesters.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : requester handshakes and register-file ports (slave modport)
// Writes: the granted command is registered onto vr_we/vr_addr_w/vr_wdata;
// the register file commits it on the next falling edge.
// Reads: the granted address is registered onto vr_addr_r, the register file
// data is captured one cycle later, and the response strobe is one-hot for
// the original requester (latency 2, no backpressure). Because the register
// file writes mid-cycle, a read granted with or after a write sees its data.
module vec_reg_port_sched
  import vec_reg_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
  input logic                  clk,
  input logic                  rst,
  vec_reg_port_sched_if.slave  bus
);

  logic [NUM_REQ-1:0]  w_wr_grant;
  logic [NUM_REQ-1:0]  w_rd_grant;
  vreg_addr_t          w_wr_addr;
  vreg_pair_t          w_wr_data;
  vreg_addr_t          w_rd_addr;
  logic [REQ_ID_W-1:0] w_rd_id;

  logic                r_vr_we;
  vreg_addr_t          r_vr_addr_w;
  vreg_pair_t          r_vr_wdata;
  vreg_addr_t          r_vr_addr_r;
  logic                r_s1_valid;
  logic [REQ_ID_W-1:0] r_s1_id;
  logic [NUM_REQ-1:0]  r_resp_valid;
  vreg_pair_t          r_resp_data;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (bus.wr_valid),
    .grant (w_wr_grant)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (bus.rd_valid),
    .grant (w_rd_grant)
  );

  // One-hot grants turn the field selection into a simple AND-OR mux.
  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    w_rd_addr = '0;
    w_rd_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_wr_grant[i]) begin
        w_wr_addr = bus.wr_addr[VREG_ADDR_W*i +: VREG_ADDR_W];
        w_wr_data = bus.wr_data[VREG_PAIR_W*i +: VREG_PAIR_W];
      end
      if (w_rd_grant[i]) begin
        w_rd_addr = bus.rd_addr[VREG_ADDR_W*i +: VREG_ADDR_W];
        w_rd_id   = REQ_ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vr_we      <= 1'b0;
      r_vr_addr_w  <= '0;
      r_vr_wdata   <= '0;
      r_vr_addr_r  <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_id      <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      // Write stage: write enable pulses for one cycle per grant.
      r_vr_we <= |w_wr_grant;
      if (|w_wr_grant) begin
        r_vr_addr_w <= w_wr_addr;
        r_vr_wdata  <= w_wr_data;
      end

      // Read stage 1: present the address to the register file.
      if (|w_rd_grant) r_vr_addr_r <= w_rd_addr;
      r_s1_valid <= |w_rd_grant;
      r_s1_id    <= w_rd_id;

      // Read stage 2: capture the pair; data holds between responses.
      r_resp_valid <= r_s1_valid ? (NUM_REQ'(1) << r_s1_id) : '0;
      if (r_s1_valid) r_resp_data <= {bus.vr_rdata2, bus.vr_rdata1};
    end
  end

  assign bus.wr_ready      = w_wr_grant;
  assign bus.rd_ready      = w_rd_grant;
  assign bus.rd_resp_valid = r_resp_valid;
  assign bus.rd_resp_data  = r_resp_data;
  assign bus.vr_we         = r_vr_we;
  assign bus.vr_addr_w     = r_vr_addr_w;
  assign bus.vr_wdata      = r_vr_wdata;
  assign bus.vr_addr_r     = r_vr_addr_r;

endmodule

// File: tb/tb_vec_reg_port_sched.sv
// Scoreboard bench for vec_reg_port_sched with two requesters. The bench
// models the register file (falling-edge pair write, combinational pair
// read). Read expectations are queued when a read is granted; a monitor pops
// and compares whenever a response strobe appears.
module tb_vec_reg_port_sched;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vec_reg_port_sched_if #(.NUM_REQ(2)) bus ();

  vec_reg_port_sched #(.NUM_REQ(2), .REQ_ID_W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file model.
  logic [31:0] rf [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};

  always @(negedge clk) begin
    if (bus.vr_we) begin
      rf[bus.vr_addr_w]         <= bus.vr_wdata[31:0];
      rf[bus.vr_addr_w + 2'd1]  <= bus.vr_wdata[63:32];
    end
  end

  assign bus.vr_rdata1 = rf[bus.vr_addr_r];
  assign bus.vr_rdata2 = rf[bus.vr_addr_r + 2'd1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  onehot;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;

  // Response monitor.
  always @(negedge clk) begin
    if (bus.rd_resp_valid != 2'b00) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_resp_unexpected: got valid=%b data=%h, required no response",
                 bus.rd_resp_valid, bus.rd_resp_data);
      end else begin
        e = q.pop_front();
        check("rd_resp_valid", 64'(bus.rd_resp_valid), 64'(e.onehot));
        check("rd_resp_data", bus.rd_resp_data, e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] oh, input logic [63:0] d);
    exp_t x;
    x.onehot = oh;
    x.data   = d;
    q.push_back(x);
  endtask

  initial begin
    rst = 1'b0;
    bus.wr_valid = 2'b11;
    bus.rd_valid = 2'b11;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr  = '0;

    // Reset with every request asserted.
    repeat (3) cyc();
    #2;
    check("rst_wr_ready",      64'(bus.wr_ready), 64'h0);
    check("rst_rd_ready",      64'(bus.rd_ready), 64'h0);
    check("rst_rd_resp_valid", 64'(bus.rd_resp_valid), 64'h0);
    check("rst_rd_resp_data",  bus.rd_resp_data, 64'h0);
    check("rst_vr_we",         64'(bus.vr_we), 64'h0);
    check("rst_vr_addr_w",     64'(bus.vr_addr_w), 64'h0);
    check("rst_vr_wdata",      bus.vr_wdata, 64'h0);
    check("rst_vr_addr_r",     64'(bus.vr_addr_r), 64'h0);
    rst = 1'b1;
    #1;
    check("first_wr_grant", 64'(bus.wr_ready), 64'h1);
    check("first_rd_grant", 64'(bus.rd_ready), 64'h1);
    bus.wr_valid = 2'b00;
    bus.rd_valid = 2'b00;
    cyc();

    // Single write from requester 1 to pair 1.
    bus.wr_addr  = 4'b0100;
    bus.wr_data  = {64'hBBBB_BBBB_AAAA_AAAA, 64'h0};
    bus.wr_valid = 2'b10;
    #1;
    check("single_wr_ready", 64'(bus.wr_ready), 64'h2);
    cyc();
    bus.wr_valid = 2'b00;
    check("single_vr_we",     64'(bus.vr_we), 64'h1);
    check("single_vr_addr_w", 64'(bus.vr_addr_w), 64'h1);
    check("single_vr_wdata",  bus.vr_wdata, 64'hBBBB_BBBB_AAAA_AAAA);
    @(negedge clk);
    #1;
    check("single_rf1", 64'(rf[1]), 64'hAAAA_AAAA);
    check("single_rf2", 64'(rf[2]), 64'hBBBB_BBBB);
    cyc();

    // Round-robin writes: both requesters hold valid for six cycles.
    bus.wr_addr  = 4'b0000;
    bus.wr_data  = {64'h0000_0011_0000_0010, 64'h0000_0001_0000_0000};
    bus.wr_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_wr_grant_%0d", k), 64'(bus.wr_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      cyc();
    end
    bus.wr_valid = 2'b00;
    cyc();
    // rf: 0=10 1=11 2=BBBBBBBB 3=A3

    // Round-robin reads: req0 at pair 0, req1 at pair 2.
    bus.rd_addr  = 4'b1000;
    bus.rd_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_rd_grant_%0d", k), 64'(bus.rd_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k % 2 == 0) push(2'b01, 64'h0000_0011_0000_0010);
      else            push(2'b10, 64'h0000_00A3_BBBB_BBBB);
      cyc();
    end
    bus.rd_valid = 2'b00;
    repeat (3) cyc();

    // Same-cycle write and read of pair 2: read sees the new data.
    bus.wr_addr  = 4'b0010;
    bus.wr_data  = {64'h0, 64'h0000_0002_0000_0001};
    bus.wr_valid = 2'b01;
    bus.rd_addr  = 4'b1000;
    bus.rd_valid = 2'b10;
    #1;
    check("fwd_wr_ready", 64'(bus.wr_ready), 64'h1);
    check("fwd_rd_ready", 64'(bus.rd_ready), 64'h2);
    push(2'b10, 64'h0000_0002_0000_0001);
    cyc();
    bus.wr_valid = 2'b00;
    bus.rd_valid = 2'b00;
    repeat (3) cyc();

    // Read at t, write to same pair at t+1: read returns the old data.
    bus.rd_addr  = 4'b0010;
    bus.rd_valid = 2'b01;
    #1;
    check("haz_rd_ready", 64'(bus.rd_ready), 64'h1);
    push(2'b01, 64'h0000_0002_0000_0001);
    cyc();
    bus.rd_valid = 2'b00;
    bus.wr_addr  = 4'b1000;
    bus.wr_data  = {64'h0000_0055_0000_0044, 64'h0};
    bus.wr_valid = 2'b10;
    #1;
    check("haz_wr_ready", 64'(bus.wr_ready), 64'h2);
    cyc();
    bus.wr_valid = 2'b00;
    repeat (3) cyc();
    // rf: 0=10 1=11 2=44 3=55

    // Pair address 3 wraps onto register 0.
    bus.wr_addr  = 4'b0011;
    bus.wr_data  = {64'h0, 64'h0000_C0DE_0000_1234};
    bus.wr_valid = 2'b01;
    #1;
    check("wrap_wr_ready", 64'(bus.wr_ready), 64'h1);
    cyc();
    bus.wr_valid = 2'b00;
    check("wrap_vr_addr_w", 64'(bus.vr_addr_w), 64'h3);
    @(negedge clk);
    #1;
    check("wrap_rf3", 64'(rf[3]), 64'h1234);
    check("wrap_rf0", 64'(rf[0]), 64'hC0DE);
    cyc();

    // Requester 1 reads pair 3 alone for three cycles: granted every cycle.
    bus.rd_addr  = 4'b1100;
    bus.rd_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("solo_rd_grant_%0d", k), 64'(bus.rd_ready), 64'h2);
      push(2'b10, 64'h0000_C0DE_0000_1234);
      cyc();
    end
    bus.rd_valid = 2'b00;
    repeat (3) cyc();

    // Reset mid-operation: grant a write and a read, then reset next cycle.
    bus.wr_addr  = 4'b0001;
    bus.wr_data  = {64'h0, 64'hDEAD_DEAD_DEAD_DEAD};
    bus.wr_valid = 2'b01;
    bus.rd_addr  = 4'b0001;
    bus.rd_valid = 2'b01;
    #1;
    check("mid_wr_ready", 64'(bus.wr_ready), 64'h1);
    check("mid_rd_ready", 64'(bus.rd_ready), 64'h1);
    cyc();
    rst = 1'b0;
    bus.wr_valid = 2'b00;
    bus.rd_valid = 2'b00;
    #1;
    check("mid_vr_we", 64'(bus.vr_we), 64'h0);
    repeat (2) cyc();
    check("mid_rf1", 64'(rf[1]), 64'h11);
    check("mid_rf2", 64'(rf[2]), 64'h44);
    rst = 1'b1;
    bus.wr_valid = 2'b11;
    bus.rd_valid = 2'b11;
    #1;
    check("post_rst_wr_grant", 64'(bus.wr_ready), 64'h1);
    check("post_rst_rd_grant", 64'(bus.rd_ready), 64'h1);
    bus.wr_valid = 2'b00;
    bus.rd_valid = 2'b00;
    repeat (4) cyc();

    check("pending_responses", 64'(q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_reg_port_sched.md
Name: vec_reg_port_sched

Overview:
- Round-robin scheduler that shares the 4x32 vector register file between NUM_REQ requesters.
- The register file has one pair-write port and one pair-read port, and writes on the falling clock edge.
- Arbitrates write and read requests independently with valid/ready handshakes.
- Registers the write command into the register file and returns 64-bit read data through a 2-cycle pipeline tagged per requester.
- Sits between the vector execution/load units and the register file.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4.
REQ_ID_W, 1, width of requester index; equals clog2(NUM_REQ).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous active-low reset; 0 = reset.
wr_valid  in  NUM_REQ  per-requester write request.
wr_addr  in  2*NUM_REQ  per-requester base pair address; requester i uses bits [2i+1:2i].
wr_data  in  64*NUM_REQ  per-requester write pair; [31:0] goes to addr, [63:32] goes to addr+1.
wr_ready  out  NUM_REQ  one-hot write grant; a transfer happens when valid&&ready.
rd_valid  in  NUM_REQ  per-requester read request.
rd_addr  in  2*NUM_REQ  per-requester read base pair address.
rd_ready  out  NUM_REQ  one-hot read grant.
rd_resp_valid  out  NUM_REQ  one-hot, single-cycle response strobe.
rd_resp_data  out  64  {reg[addr+1], reg[addr]}.
vr_we  out  1  register file write enable (registered).
vr_addr_w  out  2  register file write address (registered).
vr_wdata  out  64  register file write data (registered).
vr_addr_r  out  2  register file read address (registered).
vr_rdata1  in  32  register file reg[vr_addr_r].
vr_rdata2  in  32  register file reg[vr_addr_r+1].

Behaviour:
Reset values:
- All of the following are 0 while rst=0: wr_ready, rd_ready, rd_resp_valid, rd_resp_data, vr_we, vr_addr_w, vr_wdata, vr_addr_r.
- Both round-robin pointers reset to 0.
- Internal read-stage valids reset to 0.

Write path:
- Cycle t: wr_ready is combinational from wr_valid and wr_ptr. The granted index is the first valid requester at or after wr_ptr, wrapping modulo NUM_REQ.
- At most one wr_ready bit is high. wr_ready is never high for a requester whose wr_valid is 0.
- On the rising edge ending t, if a grant occurred:
  - vr_we<=1; vr_addr_w/vr_wdata <= winner's fields.
  - wr_ptr <= (winner+1) mod NUM_REQ.
- Otherwise vr_we<=0, vr_addr_w/vr_wdata hold, and wr_ptr holds.
- The register file commits on the falling edge inside cycle t+1.
- Sustained throughput: one write per cycle.

Read path:
- Cycle t: rd_ready is granted by the same round-robin rule using rd_ptr, independent of the write grant.
- Rising edge ending t: vr_addr_r <= winner's address; stage-1 valid and id are captured; rd_ptr advances as for writes.
- Rising edge ending t+1: rd_resp_data <= {vr_rdata2, vr_rdata1}; rd_resp_valid <= onehot(id) if stage-1 was valid, else 0.
- Response is visible in cycle t+2: latency 2, throughput 1 per cycle, no backpressure.
- rd_resp_data holds its value when no response is issued.

Ordering/hazards:
- Write granted cycle t lands at falling edge t+1. Any read granted in cycle t or later sees it.
- A read and a write granted in the same cycle to an overlapping pair: the read returns the new data (write-before-read).
- A read granted at cycle t and a write granted at t+1: the read returns the old data.
- Two writes to the same pair are applied in grant order.

Boundary conditions:
- Address 3 pairs with register 0 (2-bit wrap). Pass-through only; no error is flagged.
- A requester holding valid with no competitor is granted every cycle.
- With all NUM_REQ requesters continuously valid, each is granted exactly once per NUM_REQ cycles.
- Reset asserted mid-operation: a pending registered write is discarded (vr_we=0 immediately), in-flight reads produce no response, and pointers return to 0.
- Requests are sampled again starting in the first cycle after rst deasserts.

Decomposition:
- Package vec_reg_pkg:
  - VREG_NUM=4, VREG_ADDR_W=2, VREG_DATA_W=32, VREG_PAIR_W=64.
  - typedef vreg_addr_t (2 bits), typedef vreg_pair_t (64 bits).
- Sub-module rr_arbiter (params N; ports clk, rst, req[N], grant[N] one-hot combinational, advance pointer on any grant). Instantiated twice: write and read.

Test Plan:
- Reset: hold rst=0 with all valids=1 -> all outputs 0; after release, the first write grant goes to requester 0.
- Single write: req1 writes addr=1, data=64'hBBBB_BBBB_AAAA_AAAA at t -> vr_we=1 in t+1 with vr_addr_w=1; reg1=AAAA_AAAA and reg2=BBBB_BBBB after falling edge t+1.
- Round robin: both requesters hold wr_valid for 6 cycles -> grants alternate 0,1,0,1,0,1; the same sequence holds for reads.
- Read latency/forwarding: write addr=2 data={32'h2,32'h1} and read addr=2 in the same cycle t -> rd_resp_valid one-hot for the reader in t+2, rd_resp_data=64'h0000_0002_0000_0001.
- Wrap: write addr=3 data={32'hC0DE,32'h1234} -> reg3=0x1234, reg0=0xC0DE; a read at addr=3 returns {0xC0DE,0x1234}.
- Mid-op reset: grant a read and a write in cycle t, assert rst in t+1 -> vr_we=0 immediately, no rd_resp_valid ever fires for that read, and the register file is unchanged by the dropped write.
